dm_cache_ctrl: RTL and testbench

Read-only, direct-mapped, 4-line cache controller that sits between a CPU fetch port and a slow backing memory.
- Owns the per-line valid bits, tag store and data store.
- Performs a tag lookup for each CPU request and, on a miss, runs a single-word fill handshake with memory.
- Writes the fill into the indexed line, sets its valid bit, then returns the data.
- Serves as the control stage that drives and consumes the team's 4-line valid-bit array.

---
 rtl/cache_pkg.sv | 19 +
 rtl/cache_valid_bits.sv | 26 ++
 rtl/dm_cache_ctrl.sv | 109 ++++++++++
 tb/tb_dm_cache_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and sizing for the direct-mapped, read-only cache controller.
package cache_pkg;

    localparam int IDX_W = 2;
    localparam int LINES = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FILL   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Tag width left over once the line index is taken from the low address bits.
    function automatic int tag_w(input int addr_w);
        return addr_w - IDX_W;
    endfunction

endpackage

// File: rtl/cache_valid_bits.sv
// Per-line valid flags: set one line on a fill, clear all lines at once.
module cache_valid_bits
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             wr,
    input  logic [IDX_W-1:0] line,
    input  logic [IDX_W-1:0] rd_line,
    output logic             rd_bit
);

    logic [LINES-1:0] valid;

    // Clear has priority so a fill completing under reset leaves the line invalid.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid <= '0;
        end else if (wr) begin
            valid[line] <= 1'b1;
        end
    end

    assign rd_bit = valid[rd_line];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped 4-line read-only cache: tag lookup, single-word fill on miss, one-cycle response.
module dm_cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hit,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state
);

    localparam int TAG_W = tag_w(ADDR_W);

    state_t state, state_nxt;

    logic [ADDR_W-1:0] req_addr;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  req_tag;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];
    logic [DATA_W-1:0] rdata_q;
    logic              hit_q;
    logic              line_valid;
    logic              hit;
    logic              fill_done;
    logic              accept;

    assign idx       = req_addr[IDX_W-1:0];
    assign req_tag   = req_addr[ADDR_W-1:IDX_W];
    assign hit       = line_valid && (tag_mem[idx] == req_tag);
    assign fill_done = (state == FILL) && mem_ack;
    assign accept    = cpu_req && cpu_ready;

    cache_valid_bits u_valid (
        .clk     (clk),
        .clr     (reset || (flush && state == IDLE)),
        .wr      (fill_done),
        .line    (idx),
        .rd_line (idx),
        .rd_bit  (line_valid)
    );

    always_comb begin
        state_nxt  = state;
        cpu_ready  = 1'b0;
        cpu_rvalid = 1'b0;
        mem_req    = 1'b0;
        case (state)
            IDLE: begin
                cpu_ready = !flush;
                if (cpu_req && !flush) state_nxt = LOOKUP;
            end
            LOOKUP: state_nxt = hit ? RESP : FILL;
            FILL: begin
                mem_req = 1'b1;
                if (mem_ack) state_nxt = RESP;
            end
            RESP: begin
                cpu_rvalid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rdata_q <= '0;
            hit_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == LOOKUP && hit) begin
                rdata_q <= data_mem[idx];
                hit_q   <= 1'b1;
            end else if (fill_done) begin
                rdata_q <= mem_rdata;
                hit_q   <= 1'b0;
            end
        end
    end

    // Request address and line contents are not reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (accept && !reset) req_addr <= cpu_addr;
        if (fill_done && !reset) begin
            tag_mem[idx]  <= req_tag;
            data_mem[idx] <= mem_rdata;
        end
    end

    assign mem_addr  = req_addr;
    assign cpu_rdata = rdata_q;
    assign cpu_hit   = hit_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl with a line-level cache model and per-cycle output checker.
module tb_dm_cache_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cpu_req = 1'b0;
    logic [7:0] cpu_addr = '0;
    logic       cpu_ready;
    logic       cpu_rvalid;
    logic [7:0] cpu_rdata;
    logic       cpu_hit;
    logic       flush = 1'b0;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_rdata = '0;
    logic [1:0] dbg_state;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    dm_cache_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_ready  (cpu_ready),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_hit    (cpu_hit),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- cache model ----------------
    // Line-level view: what the cache holds, plus whether the controller is busy.
    bit         mdl_valid [4];
    logic [5:0] mdl_tag   [4];
    logic [7:0] mdl_data  [4];
    logic [7:0] cur_addr = '0;
    bit         busy_m = 1'b0;
    bit         rvalid_prev = 1'b0;
    bit         chk_on = 1'b0;
    logic [8:0] exp_q[$];

    // Acceptance rule: idle controller, request present, no flush.
    always @(posedge clk) begin
        if (reset) begin
            busy_m      = 1'b0;
            rvalid_prev = 1'b0;
        end else if (rvalid_prev) begin
            busy_m      = 1'b0;
            rvalid_prev = 1'b0;
        end else if (!busy_m && cpu_req && !flush) begin
            busy_m = 1'b1;
        end
    end

    // ---------------- scoreboard / compare ----------------
    always begin
        logic [8:0] e;
        @(negedge clk);
        #2;
        if (chk_on && !reset) begin
            check("cpu_ready", cpu_ready, !busy_m && !flush);
            if (mem_req) check("mem_addr", mem_addr, cur_addr);
            if (cpu_rvalid) begin
                rvalid_prev = 1'b1;
                if (exp_q.size() == 0) begin
                    check("rvalid_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata", cpu_rdata, e[7:0]);
                    check("hit", cpu_hit, e[8]);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) mdl_valid[i] = 1'b0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One read: waits for acceptance, acks the fill in its n_ack-th cycle,
    // and pins the model against hand-computed hit/data/latency.
    task automatic do_read(input logic [7:0] addr, input int n_ack, input logic [7:0] fill,
                           input bit exp_hit, input logic [7:0] exp_data, input int exp_lat,
                           output int acc_cyc);
        int  idx;
        int  lat;
        int  fills;
        bit  seen_mreq;
        bit  done;
        bit  m_hit;
        logic [7:0] m_data;
        idx = int'(addr[1:0]);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (cpu_ready) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) check("accept_timeout", 0, 1);
        @(posedge clk);
        acc_cyc = cyc;
        m_hit  = mdl_valid[idx] && (mdl_tag[idx] == addr[7:2]);
        m_data = m_hit ? mdl_data[idx] : fill;
        check("model_hit", m_hit, exp_hit);
        check("model_data", m_data, exp_data);
        exp_q.push_back({m_hit, m_data});
        cur_addr = addr;
        if (!m_hit) begin
            mdl_valid[idx] = 1'b1;
            mdl_tag[idx]   = addr[7:2];
            mdl_data[idx]  = fill;
        end
        @(negedge clk);
        cpu_req = 1'b0;
        lat = 1;
        fills = 0;
        seen_mreq = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            mem_ack = 1'b0;
            if (cpu_rvalid) begin
                done = 1'b1;
            end else begin
                if (mem_req) begin
                    seen_mreq = 1'b1;
                    fills++;
                    if (fills == n_ack) begin
                        mem_ack   = 1'b1;
                        mem_rdata = fill;
                    end
                end
                @(negedge clk);
                lat++;
            end
        end
        mem_ack = 1'b0;
        if (!done) check("rvalid_timeout", 0, 1);
        check("latency", lat, exp_lat);
        check("mem_req_seen", seen_mreq, !exp_hit);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int a0, a1, a2;
        bit done;
        for (int i = 0; i < 4; i++) mdl_valid[i] = 1'b0;

        do_reset();
        chk_on = 1'b1;
        #1;
        check("rst_ready", cpu_ready, 1);
        check("rst_rvalid", cpu_rvalid, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_rdata", cpu_rdata, 8'h00);
        check("rst_hit", cpu_hit, 0);
        @(negedge clk);

        // cold miss, repeat hit, conflict eviction
        do_read(8'h15, 3, 8'hA5, 0, 8'hA5, 5, a0);
        do_read(8'h15, 1, 8'h00, 1, 8'hA5, 2, a0);
        do_read(8'h19, 2, 8'h3C, 0, 8'h3C, 4, a0);
        do_read(8'h19, 1, 8'h00, 1, 8'h3C, 2, a0);
        do_read(8'h15, 2, 8'h5A, 0, 8'h5A, 4, a0);

        // stray ack in IDLE must not disturb anything
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 8'hEE;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        do_read(8'h15, 1, 8'h00, 1, 8'h5A, 2, a0);

        // flush beats a simultaneous request
        @(negedge clk);
        flush    = 1'b1;
        cpu_req  = 1'b1;
        cpu_addr = 8'h19;
        #1;
        check("ready_during_flush", cpu_ready, 0);
        @(negedge clk);
        flush   = 1'b0;
        cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) mdl_valid[i] = 1'b0;
        repeat (3) @(negedge clk);
        do_read(8'h19, 2, 8'h77, 0, 8'h77, 4, a0);

        // back-to-back hits: one accepted every 3 cycles
        do_read(8'h19, 1, 8'h00, 1, 8'h77, 2, a1);
        do_read(8'h19, 1, 8'h00, 1, 8'h77, 2, a2);
        check("b2b_spacing", a2 - a1, 3);

        // reset in the middle of a fill, then a late ack
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 8'h2A;
        cur_addr = 8'h2A;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            if (mem_req) done = 1'b1;
            else @(negedge clk);
        end
        check("abort_mem_req_rose", done, 1);
        @(negedge clk);
        do_reset();
        #1;
        check("abort_mem_req_dropped", mem_req, 0);
        check("abort_no_rvalid", cpu_rvalid, 0);
        mem_ack   = 1'b1;
        mem_rdata = 8'h99;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        do_read(8'h2A, 2, 8'h44, 0, 8'h44, 4, a0);
        do_read(8'h2A, 1, 8'h00, 1, 8'h44, 2, a0);

        repeat (4) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
